// File: rtl/bus_pkg.sv
// Shared types for the fetch/execute memory bus arbiter.
// Struct fields are sized to the widest supported bus (64-bit address,
// 64-bit data); narrower instances zero-extend into them.
package bus_pkg;

  localparam int BUS_ADDR_MAX = 64;
  localparam int BUS_DATA_MAX = 64;
  localparam int BUS_STRB_MAX = BUS_DATA_MAX / 8;

  typedef struct packed {
    logic [BUS_ADDR_MAX-1:0] addr;
    logic [BUS_DATA_MAX-1:0] wdata;
    logic [BUS_STRB_MAX-1:0] wstrb;
    logic                    write;
  } bus_req_t;

  typedef struct packed {
    logic [BUS_DATA_MAX-1:0] rdata;
    logic                    err;
  } bus_resp_t;

  typedef enum logic {
    REQ_FETCH   = 1'b0,
    REQ_EXECUTE = 1'b1
  } requester_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_arb_select.sv
// Winner selection for the bus arbiter: execute has fixed priority, but after
// STARVE_LIMIT consecutive execute grants with fetch waiting, fetch wins once.
module arb_select
  import bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arb_en,
  input  logic       f_valid,
  input  logic       e_valid,
  output logic       grant_valid,
  output requester_e winner
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_r;

  // Combinational winner choice for the current arbitration cycle.
  always_comb begin
    grant_valid = arb_en & (f_valid | e_valid);
    winner      = REQ_EXECUTE;
    if (f_valid && !e_valid) begin
      winner = REQ_FETCH;
    end else if (f_valid && e_valid && (starve_cnt_r == LIMIT_C)) begin
      winner = REQ_FETCH;
    end else begin
      winner = REQ_EXECUTE;
    end
  end

  // Count execute grants made while fetch waits; saturate at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_r <= '0;
    end else if (arb_en) begin
      if (!f_valid) begin
        starve_cnt_r <= '0;
      end else if (grant_valid && (winner == REQ_FETCH)) begin
        starve_cnt_r <= '0;
      end else if (grant_valid && (starve_cnt_r != LIMIT_C)) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Fetch/execute to single memory bus arbiter with one outstanding transaction.
// Optional WAIT-state timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                f_req_valid,
  output logic                f_req_ready,
  input  logic [ADDR_W-1:0]   f_req_addr,
  input  logic [DATA_W-1:0]   f_req_wdata,
  input  logic [DATA_W/8-1:0] f_req_wstrb,
  input  logic                f_req_write,
  output logic                f_resp_valid,
  output logic [DATA_W-1:0]   f_resp_rdata,
  output logic                f_resp_err,
  input  logic                e_req_valid,
  output logic                e_req_ready,
  input  logic [ADDR_W-1:0]   e_req_addr,
  input  logic [DATA_W-1:0]   e_req_wdata,
  input  logic [DATA_W/8-1:0] e_req_wstrb,
  input  logic                e_req_write,
  output logic                e_resp_valid,
  output logic [DATA_W-1:0]   e_resp_rdata,
  output logic                e_resp_err,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wstrb,
  output logic                m_req_write,
  input  logic                m_resp_valid,
  input  logic [DATA_W-1:0]   m_resp_rdata,
  input  logic                m_resp_err
);

  arb_state_e state_r, state_s;
  bus_req_t   req_r, req_sel_s;
  bus_resp_t  f_resp_r, e_resp_r, resp_s;
  requester_e owner_r, winner_s;
  logic       idle_s, grant_s, timeout_s;
  logic       m_req_valid_r, f_resp_valid_r, e_resp_valid_r;

  assign idle_s = (state_r == IDLE);

  arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clock       (clock),
    .reset       (reset),
    .arb_en      (idle_s),
    .f_valid     (f_req_valid),
    .e_valid     (e_req_valid),
    .grant_valid (grant_s),
    .winner      (winner_s)
  );

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt_r;

  // Count WAIT cycles; zero in every other state so each WAIT starts fresh.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (state_r != WAIT) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + TO_W'(1);
    end
  end

  assign timeout_s = (state_r == WAIT) && !m_resp_valid &&
                     (wait_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (TIMEOUT_CYCLES > 0);
  assign timeout_s    = 1'b0;
`endif

  // Grant handshake back to the winning requester, only while arbitrating.
  always_comb begin
    f_req_ready = 1'b0;
    e_req_ready = 1'b0;
    if (grant_s) begin
      if (winner_s == REQ_FETCH) begin
        f_req_ready = 1'b1;
      end else begin
        e_req_ready = 1'b1;
      end
    end else begin
      f_req_ready = 1'b0;
      e_req_ready = 1'b0;
    end
  end

  // Mux the winner's request fields, zero-extended into the shared struct.
  always_comb begin
    req_sel_s = '0;
    if (winner_s == REQ_FETCH) begin
      req_sel_s.addr  = BUS_ADDR_MAX'(f_req_addr);
      req_sel_s.wdata = BUS_DATA_MAX'(f_req_wdata);
      req_sel_s.wstrb = BUS_STRB_MAX'(f_req_wstrb);
      req_sel_s.write = f_req_write;
    end else begin
      req_sel_s.addr  = BUS_ADDR_MAX'(e_req_addr);
      req_sel_s.wdata = BUS_DATA_MAX'(e_req_wdata);
      req_sel_s.wstrb = BUS_STRB_MAX'(e_req_wstrb);
      req_sel_s.write = e_req_write;
    end
  end

  // Response to forward: memory data on reads, zero data on writes/errors/timeout.
  always_comb begin
    resp_s = '0;
    if (m_resp_valid) begin
      resp_s.err = m_resp_err;
      if (req_r.write || m_resp_err) begin
        resp_s.rdata = '0;
      end else begin
        resp_s.rdata = BUS_DATA_MAX'(m_resp_rdata);
      end
    end else begin
      resp_s.err   = 1'b1;
      resp_s.rdata = '0;
    end
  end

  // Next-state logic of the single-outstanding transaction FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) state_s = ISSUE;
        else         state_s = IDLE;
      end
      ISSUE: begin
        if (m_req_ready) state_s = WAIT;
        else             state_s = ISSUE;
      end
      WAIT: begin
        if (m_resp_valid || timeout_s) state_s = RESP;
        else                           state_s = WAIT;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Latch the granted request and remember who owns the transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_r   <= '0;
      owner_r <= REQ_FETCH;
    end else if (idle_s && grant_s) begin
      req_r   <= req_sel_s;
      owner_r <= winner_s;
    end
  end

  // Downstream request valid, registered for the whole ISSUE state.
  always_ff @(posedge clock) begin
    if (reset) m_req_valid_r <= 1'b0;
    else       m_req_valid_r <= (state_s == ISSUE);
  end

  // Capture the response for the owner and pulse its valid for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      f_resp_r       <= '0;
      e_resp_r       <= '0;
      f_resp_valid_r <= 1'b0;
      e_resp_valid_r <= 1'b0;
    end else begin
      f_resp_valid_r <= 1'b0;
      e_resp_valid_r <= 1'b0;
      if ((state_r == WAIT) && (state_s == RESP)) begin
        if (owner_r == REQ_FETCH) begin
          f_resp_r       <= resp_s;
          f_resp_valid_r <= 1'b1;
        end else begin
          e_resp_r       <= resp_s;
          e_resp_valid_r <= 1'b1;
        end
      end
    end
  end

  assign m_req_valid  = m_req_valid_r;
  assign m_req_addr   = req_r.addr[ADDR_W-1:0];
  assign m_req_wdata  = req_r.wdata[DATA_W-1:0];
  assign m_req_wstrb  = req_r.wstrb[DATA_W/8-1:0];
  assign m_req_write  = req_r.write;

  assign f_resp_valid = f_resp_valid_r;
  assign f_resp_rdata = f_resp_r.rdata[DATA_W-1:0];
  assign f_resp_err   = f_resp_r.err;
  assign e_resp_valid = e_resp_valid_r;
  assign e_resp_rdata = e_resp_r.rdata[DATA_W-1:0];
  assign e_resp_err   = e_resp_r.err;

  // Upper struct bits beyond this instance's widths stay zero and are unread.
  logic unused_wide_s;
  assign unused_wide_s = ^{req_r, f_resp_r, e_resp_r};

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        f_req_valid = 1'b0, e_req_valid = 1'b0;
  logic        f_req_ready, e_req_ready;
  logic [31:0] f_req_addr = 32'h0, e_req_addr = 32'h0;
  logic [31:0] f_req_wdata = 32'h0, e_req_wdata = 32'h0;
  logic [3:0]  f_req_wstrb = 4'h0, e_req_wstrb = 4'h0;
  logic        f_req_write = 1'b0, e_req_write = 1'b0;
  logic        f_resp_valid, e_resp_valid, f_resp_err, e_resp_err;
  logic [31:0] f_resp_rdata, e_resp_rdata;
  logic        m_req_valid, m_req_write;
  logic        m_req_ready = 1'b0;
  logic [31:0] m_req_addr, m_req_wdata;
  logic [3:0]  m_req_wstrb;
  logic        m_resp_valid = 1'b0;
  logic [31:0] m_resp_rdata = 32'h0;
  logic        m_resp_err = 1'b0;

  int          n_checks = 0;
  int          n_pass = 0;
  int          stall_left = 0;
  bit          mem_respond = 1'b1;
  bit          hs_pend = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_err = 1'b0;

  always #5 clock = ~clock;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_req_wdata(f_req_wdata), .f_req_wstrb(f_req_wstrb), .f_req_write(f_req_write),
    .f_resp_valid(f_resp_valid), .f_resp_rdata(f_resp_rdata), .f_resp_err(f_resp_err),
    .e_req_valid(e_req_valid), .e_req_ready(e_req_ready), .e_req_addr(e_req_addr),
    .e_req_wdata(e_req_wdata), .e_req_wstrb(e_req_wstrb), .e_req_write(e_req_write),
    .e_resp_valid(e_resp_valid), .e_resp_rdata(e_resp_rdata), .e_resp_err(e_resp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb), .m_req_write(m_req_write),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err)
  );

  // Memory model: stalls m_req_ready for stall_left ISSUE cycles, then answers
  // one cycle after the handshake (unless mem_respond is cleared).
  always @(negedge clock) begin
    m_resp_valid = 1'b0;
    m_resp_rdata = 32'h0;
    m_resp_err   = 1'b0;
    if (hs_pend && mem_respond) begin
      m_resp_valid = 1'b1;
      m_resp_rdata = mem_rdata;
      m_resp_err   = mem_err;
    end
    hs_pend = 1'b0;
    if (m_req_valid && (stall_left == 0)) begin
      m_req_ready = 1'b1;
      hs_pend     = 1'b1;
    end else begin
      m_req_ready = 1'b0;
      if (m_req_valid) stall_left = stall_left - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_resp(input bit fetch, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (fetch ? f_resp_valid : e_resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int grants;
    bit exp_f [10];
    exp_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) step();
    check("reset_outputs",
          {f_req_ready, e_req_ready, f_resp_valid, e_resp_valid, m_req_valid,
           m_req_addr, f_resp_err, e_resp_err, m_req_write},
          64'h0);
    check("reset_data", {f_resp_rdata, e_resp_rdata}, 64'h0);
    reset = 1'b0;
    step();

    // Fetch-only read of 0x10
    mem_rdata   = 32'hDEAD_BEEF;
    f_req_valid = 1'b1;
    f_req_addr  = 32'h0000_0010;
    #1;
    check("t1_ready", {f_req_ready, e_req_ready}, 64'h2);
    step();
    f_req_valid = 1'b0;
    check("t1_issue", {m_req_valid, m_req_write, m_req_addr}, {30'h0, 1'b1, 1'b0, 32'h10});
    step();
    check("t1_wait_novalid", f_resp_valid, 64'h0);
    step();
    check("t1_resp", {f_resp_valid, f_resp_err, e_resp_valid, f_resp_rdata},
          {29'h0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF});
    step();
    check("t1_resp_one_cycle", f_resp_valid, 64'h0);

    // Both valid continuously: E,E,E,E,F,E,E,E,E,F
    f_req_valid = 1'b1; f_req_addr = 32'h0000_1000;
    e_req_valid = 1'b1; e_req_addr = 32'h0000_2000;
    #1;
    grants = 0;
    for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
      if (f_req_ready || e_req_ready) begin
        check($sformatf("t2_grant%0d", grants), {f_req_ready, e_req_ready},
              exp_f[grants] ? 64'h2 : 64'h1);
        grants++;
      end
      step();
    end
    check("t2_grant_count", grants, 64'd10);
    f_req_valid = 1'b0;
    e_req_valid = 1'b0;
    wait_resp(1'b1, 10, ok);
    check("t2_last_resp", ok, 64'h1);
    step();

    // Execute write: fields pass through, response data forced to zero
    mem_rdata   = 32'hFFFF_FFFF;
    e_req_valid = 1'b1; e_req_addr = 32'h100; e_req_wdata = 32'h1234_5678;
    e_req_wstrb = 4'b0011; e_req_write = 1'b1;
    #1;
    check("t3_ready", {f_req_ready, e_req_ready}, 64'h1);
    step();
    e_req_valid = 1'b0;
    check("t3_fields", {m_req_valid, m_req_write, m_req_wstrb, m_req_addr[15:0], m_req_wdata},
          {10'h0, 1'b1, 1'b1, 4'b0011, 16'h0100, 32'h1234_5678});
    wait_resp(1'b0, 10, ok);
    check("t3_resp_seen", ok, 64'h1);
    check("t3_resp", {f_resp_valid, e_resp_err, e_resp_rdata}, 64'h0);
    step();
    e_req_write = 1'b0;

    // Memory stalls m_req_ready for 10 cycles
    mem_rdata   = 32'hCAFE_0001;
    stall_left  = 10;
    f_req_valid = 1'b1; f_req_addr = 32'h300;
    e_req_valid = 1'b1; e_req_addr = 32'h200;
    #1;
    check("t4_ready", {f_req_ready, e_req_ready}, 64'h1);
    step();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t4_stable%0d", i), {m_req_valid, m_req_addr, f_req_ready, e_req_ready},
            {29'h0, 1'b1, 32'h200, 1'b0, 1'b0});
      step();
    end
    f_req_valid = 1'b0;
    e_req_valid = 1'b0;
    wait_resp(1'b0, 10, ok);
    check("t4_resp", {ok, f_resp_valid, e_resp_rdata}, {30'h0, 1'b1, 1'b0, 32'hCAFE_0001});
    step();

    // Reset asserted in WAIT abandons the transaction
    mem_respond = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 32'h40;
    step();
    f_req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_after_reset",
          {m_req_valid, f_resp_valid, e_resp_valid, f_req_ready, e_req_ready, m_req_addr},
          64'h0);
    check("t5_after_reset_data", {f_resp_rdata, e_resp_rdata}, 64'h0);
    mem_respond = 1'b1;
    step();
    check("t5_no_stray", {f_resp_valid, e_resp_valid}, 64'h0);
    mem_rdata   = 32'h0BAD_F00D;
    f_req_valid = 1'b1; f_req_addr = 32'h44;
    #1;
    check("t5_ready", {f_req_ready, e_req_ready}, 64'h2);
    step();
    f_req_valid = 1'b0;
    wait_resp(1'b1, 10, ok);
    check("t5_resp", {ok, f_resp_err, f_resp_rdata}, {31'h0, 1'b1, 1'b0, 32'h0BAD_F00D});
    step();

`ifdef BUS_ARBITER_TIMEOUT_EN
    // No memory response: error after the 8th WAIT cycle
    mem_respond = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 32'h80;
    step();
    f_req_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t6_quiet%0d", i), f_resp_valid, 64'h0);
      step();
    end
    check("t6_timeout", {f_resp_valid, f_resp_err, f_resp_rdata}, {30'h0, 1'b1, 1'b1, 32'h0});
    step();
    mem_respond = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbitrates the instruction-fetch and execute (load/store) memory requests of the control unit onto the single downstream memory bus. It sits directly downstream of the fetch and execute stages. It holds at most one outstanding transaction and routes each response back to the requester that issued it. Execute has fixed priority, with a starvation guard so that fetch always makes progress.

## Interface
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width; the write strobe is DATA_W/8 bits wide.
- STARVE_LIMIT, default 4: consecutive execute grants allowed while fetch waits; minimum 1.
- TIMEOUT_CYCLES, default 255: WAIT-state cycles before an error response (used only with the macro).
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- f_req_valid / e_req_valid  in  1  request present (f = fetch, e = execute).
- f_req_ready / e_req_ready  out  1  request accepted this cycle.
- f_req_addr / e_req_addr  in  ADDR_W  byte address.
- f_req_wdata / e_req_wdata  in  DATA_W  write data.
- f_req_wstrb / e_req_wstrb  in  DATA_W/8  byte enables.
- f_req_write / e_req_write  in  1  1 = write, 0 = read.
- f_resp_valid / e_resp_valid  out  1  one-cycle response pulse; no back-pressure.
- f_resp_rdata / e_resp_rdata  out  DATA_W  read data; 0 on writes and errors.
- f_resp_err / e_resp_err  out  1  error flag, qualified by resp_valid.
- m_req_valid  out  1; m_req_ready  in  1  downstream request handshake.
- m_req_addr / m_req_wdata / m_req_wstrb / m_req_write  out  request fields.
- m_resp_valid  in  1; m_resp_rdata  in  DATA_W; m_resp_err  in  1  downstream response.

## Operation
- FSM states and transitions:
  - IDLE: if any request is valid, pick a winner, assert its req_ready combinationally, latch its fields and owner ID, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: m_req_valid=1 with the latched fields, held stable. Go to WAIT on m_req_ready.
  - WAIT: on m_resp_valid, register rdata/err into the owner's response outputs and go to RESP.
  - RESP: owner's resp_valid=1 for exactly one cycle, then go to IDLE.
- Winner selection in IDLE:
  - Only one valid requester: that requester wins.
  - Both valid: execute wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - Increments, saturating, on each execute grant made while f_req_valid=1.
  - Clears on a fetch grant.
  - Clears on any IDLE arbitration where f_req_valid=0.
- The non-owner never sees req_ready or resp_valid. req_ready is never asserted outside IDLE.
- m_resp_valid outside WAIT is discarded.
- Reset values:
  - State IDLE, starve_cnt 0.
  - All ready/valid outputs 0; all data, addr and err outputs 0.
- Reset mid-transaction abandons it; no response is issued to either requester.

## Timing
- Request accepted in cycle T; m_req_valid asserted from T+1.
- m_resp_valid sampled in cycle R; owner's resp_valid asserted in R+1.
- Next acceptance no earlier than R+2.
- With a zero-wait memory (m_req_ready and m_resp_valid arrive in the first possible cycles), one transaction completes every 4 cycles.
- Requesters must hold their request fields stable while valid=1 and ready=0.

## Configuration
- BUS_ARBITER_TIMEOUT_EN defined:
  - A counter runs in WAIT, cleared on entry.
  - At TIMEOUT_CYCLES with no m_resp_valid, go to RESP with err=1 and rdata=0.
  - The memory must not respond after a timeout; a late response is treated as discarded or stray.
- BUS_ARBITER_TIMEOUT_EN undefined: no counter; WAIT lasts until m_resp_valid.

## Structure
- Shared package bus_pkg holds:
  - bus_req_t (addr, wdata, wstrb, write) and bus_resp_t (rdata, err).
  - requester_e (REQ_FETCH, REQ_EXECUTE).
  - arb_state_e (IDLE, ISSUE, WAIT, RESP).
- One sub-module, arb_select: combinational winner choice plus the starve_cnt register and its update rules.

## Test plan
- Fetch-only read of 0x0000_0010, memory returns 0xDEAD_BEEF → f_resp_valid for one cycle with rdata 0xDEAD_BEEF, err=0; e_resp_valid stays 0.
- Both valid continuously, STARVE_LIMIT=4 → grant order E,E,E,E,F,E,E,E,E,F.
- Execute write to 0x100 with wdata 0x1234_5678, wstrb 4'b0011 → m_req fields match exactly; response has rdata 0.
- m_req_ready held low for 10 cycles → m_req fields stable throughout and no req_ready asserted to either requester.
- reset asserted in WAIT → next cycle IDLE with all outputs 0; a following fetch request completes normally.
- With BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, no memory response → owner's resp_valid with err=1 on the cycle after the 8th WAIT cycle.
